mem_cache: RTL

MEM_CACHE -- requirements
Module: mem_cache

---
 rtl/mem_cache.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/mem_cache.sv
// mem_cache: direct-mapped, one-word-per-line, write-through / no-allocate cache.
//
// Ports
//   clk, reset              single clock, asynchronous active-high reset
//   cpu_read, cpu_write     CPU request strobes, held until cpu_ready
//   cpu_addr                CPU byte address (bits [1:0] ignored)
//   cpu_write_data          CPU store data
//   cpu_read_data           load data, valid while cpu_ready=1 on a read
//   cpu_ready               one-cycle completion strobe
//   flush                   one-cycle pulse, invalidates every line
//   mem_read, mem_write     backing-memory strobes (never both high)
//   mem_addr                backing-memory word-aligned byte address
//   mem_write_data          backing-memory store data
//   mem_read_data           backing-memory load data (combinational)
//   hit_count, miss_count   saturating read hit / miss counters
module mem_cache #(
    parameter int LINES    = 16,
    parameter int MEM_WAIT = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_read,
    input  logic        cpu_write,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_write_data,
    output logic [31:0] cpu_read_data,
    output logic        cpu_ready,
    input  logic        flush,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_write_data,
    input  logic [31:0] mem_read_data,
    output logic [15:0] hit_count,
    output logic [15:0] miss_count
);

    localparam int IW = $clog2(LINES);
    localparam int TW = 30 - IW;
    localparam int CW = $clog2(MEM_WAIT + 1);

    typedef enum logic [1:0] {IDLE, FILL, WRITE} state_t;

    state_t            state;
    logic [CW-1:0]     wait_cnt;
    logic              flush_pend;
    logic [LINES-1:0]  valid;
    logic [TW-1:0]     tag_mem  [LINES];
    logic [31:0]       data_mem [LINES];

    logic [IW-1:0]     req_idx, mem_idx;
    logic [TW-1:0]     req_tag, mem_tag;
    logic              hit, wr_hit, rd_req, fill_done;
    logic              unused_addr_bits;

    assign unused_addr_bits = ^cpu_addr[1:0];

    assign req_idx = cpu_addr[IW+1:2];
    assign req_tag = cpu_addr[31:IW+2];
    // During FILL/WRITE the registered memory address identifies the line.
    assign mem_idx = mem_addr[IW+1:2];
    assign mem_tag = mem_addr[31:IW+2];

    assign hit       = valid[req_idx] && (tag_mem[req_idx] == req_tag);
    assign wr_hit    = valid[mem_idx] && (tag_mem[mem_idx] == mem_tag);
    // A simultaneous write wins, so a read is only a read when write is low.
    assign rd_req    = (state == IDLE) && cpu_read && !cpu_write;
    assign fill_done = (state == FILL) && (wait_cnt == CW'(1));

    always_comb begin
        cpu_ready     = 1'b0;
        cpu_read_data = 32'd0;
        if (rd_req && hit) begin
            cpu_ready     = 1'b1;
            cpu_read_data = data_mem[req_idx];
        end else if (fill_done) begin
            cpu_ready     = 1'b1;
            cpu_read_data = mem_read_data;
        end else if (state == WRITE) begin
            cpu_ready     = 1'b1;
        end
    end

    // Control, valid bits, counters and registered memory interface.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            wait_cnt       <= '0;
            flush_pend     <= 1'b0;
            valid          <= '0;
            mem_read       <= 1'b0;
            mem_write      <= 1'b0;
            mem_addr       <= 32'd0;
            mem_write_data <= 32'd0;
            hit_count      <= 16'd0;
            miss_count     <= 16'd0;
        end else begin
            case (state)
                IDLE: begin
                    // Request lookup above uses pre-flush contents.
                    if (flush || flush_pend) begin
                        valid      <= '0;
                        flush_pend <= 1'b0;
                    end
                    if (cpu_write) begin
                        mem_addr       <= {cpu_addr[31:2], 2'b00};
                        mem_write_data <= cpu_write_data;
                        mem_write      <= 1'b1;
                        state          <= WRITE;
                    end else if (cpu_read) begin
                        if (hit) begin
                            if (hit_count != 16'hFFFF) hit_count <= hit_count + 16'd1;
                        end else begin
                            if (miss_count != 16'hFFFF) miss_count <= miss_count + 16'd1;
                            mem_addr <= {cpu_addr[31:2], 2'b00};
                            mem_read <= 1'b1;
                            wait_cnt <= CW'(MEM_WAIT);
                            state    <= FILL;
                        end
                    end
                end
                FILL: begin
                    if (flush) flush_pend <= 1'b1;
                    wait_cnt <= wait_cnt - CW'(1);
                    if (wait_cnt == CW'(1)) begin
                        valid[mem_idx] <= 1'b1;
                        mem_read       <= 1'b0;
                        state          <= IDLE;
                    end
                end
                WRITE: begin
                    if (flush) flush_pend <= 1'b1;
                    mem_write <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Tag/data arrays carry no reset; the valid bits alone qualify them.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (fill_done) begin
                tag_mem[mem_idx]  <= mem_tag;
                data_mem[mem_idx] <= mem_read_data;
            end else if (state == WRITE && wr_hit) begin
                data_mem[mem_idx] <= mem_write_data;
            end
        end
    end

endmodule
